// File: rtl/syscfg_pkg.sv
// Shared register offsets, version and sequencer state type for the
// APB system-configuration block.
package syscfg_pkg;

  localparam logic [3:0]  OFF_BOOT   = 4'h0;
  localparam logic [3:0]  OFF_RST    = 4'h4;
  localparam logic [3:0]  OFF_PULSE  = 4'h8;
  localparam logic [3:0]  OFF_STATUS = 4'hC;

  localparam logic [11:0] ADDR_INFO  = 12'hF00;
  localparam logic [11:0] ADDR_LOCK  = 12'hF04;

  localparam logic [15:0] SYSCFG_VERSION = 16'h0002;

  typedef enum logic {
    IDLE   = 1'b0,
    ASSERT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/syscfg_rst_seq.sv
// Timed reset-pulse sequencer: holds busy high for HOLD cycles after start.
module syscfg_rst_seq
  import syscfg_pkg::*;
#(
  parameter int HOLD = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic start,
  output logic busy
);

  seq_state_e  state;
  logic [15:0] cnt;

  // Counter runs HOLD-1 down to 0, so ASSERT lasts exactly HOLD cycles.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ASSERT;
            cnt   <= 16'(HOLD - 1);
            busy  <= 1'b1;
          end
        end
        ASSERT: begin
          if (cnt == 16'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/apb_syscfg_ctrl.sv
// APB system-configuration slave: per-complex boot vectors, level resets,
// timed reset pulses, plus a global info register and write-once lock.
module apb_syscfg_ctrl
  import syscfg_pkg::*;
#(
  parameter int          APB_ADDR_WIDTH  = 12,
  parameter int          NUM_CC          = 2,
  parameter logic [31:0] BOOT_RST_VAL    = 32'h0001_0000,
  parameter int          RST_HOLD_CYCLES = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [NUM_CC-1:0][31:0]   cfg_cc_boot,
  output logic [NUM_CC-1:0]         cfg_cc_rst
);

  localparam logic [31:0] INFO_VAL = {SYSCFG_VERSION, 8'h00, 8'(NUM_CC)};

  logic [NUM_CC-1:0][31:0] boot_q;
  logic [NUM_CC-1:0]       rst_q;
  logic                    lock_q;
  logic [NUM_CC-1:0]       busy;
  logic [NUM_CC-1:0]       pulse_start;

  logic [7:0]  idx;
  logic [3:0]  off;
  logic [11:0] gaddr;
  logic        access;
  logic        wr_en;
  logic        rd_en;
  logic        wr_ok;
  logic        rd_ok;
  logic        err;
  logic        cc_hit;
  logic        info_hit;
  logic        lock_hit;
  logic        misaligned;
  logic        bad_write;

  logic [NUM_CC-1:0] cc_sel;
  logic [31:0]       sel_boot;
  logic              sel_rst;
  logic              sel_busy;
  logic [31:0]       rdata;

  assign idx        = PADDR[11:4];
  assign off        = PADDR[3:0];
  assign gaddr      = PADDR[11:0];
  assign access     = PSEL & PENABLE;
  assign wr_en      = access & PWRITE;
  assign rd_en      = access & ~PWRITE;
  assign info_hit   = (gaddr == ADDR_INFO);
  assign lock_hit   = (gaddr == ADDR_LOCK);
  assign misaligned = (PADDR[1:0] != 2'b00);

  always_comb begin
    cc_sel   = '0;
    sel_boot = '0;
    sel_rst  = 1'b0;
    sel_busy = 1'b0;
    for (int i = 0; i < NUM_CC; i++) begin
      if (idx == 8'(i)) begin
        cc_sel[i] = 1'b1;
        sel_boot  = boot_q[i];
        sel_rst   = rst_q[i];
        sel_busy  = busy[i];
      end
    end
  end

  assign cc_hit = |cc_sel;

  // Rejected writes leave all state untouched; they only raise PSLVERR.
  assign bad_write = info_hit
                   | (cc_hit & (off == OFF_STATUS))
                   | (cc_hit & (off == OFF_BOOT) & lock_q)
                   | (cc_hit & (off == OFF_PULSE) & PWDATA[0] & sel_busy);

  assign err   = ~(cc_hit | info_hit | lock_hit) | misaligned | (PWRITE & bad_write);
  assign wr_ok = wr_en & ~err;
  assign rd_ok = rd_en & ~err;

  always_comb begin
    rdata = '0;
    if (rd_ok) begin
      if (info_hit) begin
        rdata = INFO_VAL;
      end else if (lock_hit) begin
        rdata = {31'b0, lock_q};
      end else begin
        case (off)
          OFF_BOOT:   rdata = sel_boot;
          OFF_RST:    rdata = {31'b0, sel_rst};
          OFF_STATUS: rdata = {30'b0, sel_busy, sel_rst | sel_busy};
          default:    rdata = '0;
        endcase
      end
    end
  end

  assign PRDATA  = rdata;
  assign PSLVERR = access & err;
  assign PREADY  = 1'b1;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      boot_q <= {NUM_CC{BOOT_RST_VAL}};
      rst_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CC; i++) begin
        if (wr_ok && cc_sel[i] && (off == OFF_BOOT)) begin
          boot_q[i] <= PWDATA;
        end
        if (wr_ok && cc_sel[i] && (off == OFF_RST)) begin
          rst_q[i] <= PWDATA[0];
        end
      end
      if (wr_ok && lock_hit && PWDATA[0]) begin
        lock_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CC; g++) begin : g_seq
    assign pulse_start[g] = wr_ok & cc_sel[g] & (off == OFF_PULSE) & PWDATA[0];

    syscfg_rst_seq #(
      .HOLD (RST_HOLD_CYCLES)
    ) u_seq (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .start   (pulse_start[g]),
      .busy    (busy[g])
    );
  end

  assign cfg_cc_boot = boot_q;
  assign cfg_cc_rst  = rst_q | busy;

endmodule

// File: doc/apb_syscfg_ctrl.md
# apb_syscfg_ctrl

Parametrised APB system-configuration slave for NUM_CC core complexes. Each core complex gets a boot-address register, a level reset control, and a timed reset-pulse sequencer, plus a global info register and a write-once lock. It replaces the fixed two-complex config block on the peripheral APB bus. Outputs drive core-complex boot vectors and reset inputs directly.

## Interface
Parameters:
- APB_ADDR_WIDTH, 12: PADDR width. Must be at least 12.
- NUM_CC, 2: number of core complexes, 1..16.
- BOOT_RST_VAL, 32'h0001_0000: reset value of every boot register.
- RST_HOLD_CYCLES, 16: length in PCLK cycles of a sequencer reset pulse, 1..65535.

Ports:
- PCLK  in  1  sole clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- PADDR  in  APB_ADDR_WIDTH  APB address.
- PWDATA  in  32  write data.
- PWRITE, PSEL, PENABLE  in  1  APB controls.
- PRDATA  out  32  read data.
- PREADY  out  1  tied to 1.
- PSLVERR  out  1  error response.
- cfg_cc_boot  out  NUM_CC×32  per-complex boot address.
- cfg_cc_rst  out  NUM_CC  per-complex reset request, active-high.

## Operation
- Access qualifiers: wr_en = PSEL&PENABLE&PWRITE; rd_en = PSEL&PENABLE&~PWRITE.
- Per-complex register map, with i = PADDR[11:4] and i < NUM_CC:
  - 0x0 BOOT: RW, 32 bits.
  - 0x4 RST: RW, bit0 only; other bits read 0.
  - 0x8 PULSE: write-only; writing bit0=1 starts the sequencer; reads return 0.
  - 0xC STATUS: RO; bit0 = cfg_cc_rst[i], bit1 = sequencer busy.
- Global registers:
  - 0xF00 INFO: RO; [7:0] NUM_CC, [31:16] 16'h0002 (version).
  - 0xF04 LOCK: bit0 is write-once-to-1. Once set, BOOT writes are blocked. Only PRESETn clears it.
- PSLVERR=1 during the access phase, with no state change, for any of:
  - unmapped address (i ≥ NUM_CC and not 0xF00/0xF04);
  - PADDR[1:0] ≠ 0;
  - write to STATUS or INFO;
  - BOOT write while LOCK=1;
  - PULSE bit0 write while the target sequencer is busy.
- PULSE write with bit0=0 is accepted with no effect. A LOCK write with bit0=0 has no effect.
- Sequencer per complex:
  - States: IDLE, ASSERT.
  - IDLE → ASSERT on an accepted PULSE write; the counter loads RST_HOLD_CYCLES-1.
  - ASSERT decrements each cycle and returns to IDLE on the cycle after the counter reaches 0.
  - Busy = (state==ASSERT).
- cfg_cc_rst[i] = RST[i].bit0 | (seq_state[i]==ASSERT).
- Reset values:
  - BOOT = BOOT_RST_VAL; RST = 0; LOCK = 0.
  - Sequencers IDLE, counters 0.
  - cfg_cc_rst = 0; PRDATA = 0; PSLVERR = 0.

## Timing
- Zero wait states. PREADY is constant 1.
- Write in access cycle T: the register updates at the closing edge of T. The output is visible in T+1.
- PULSE accepted in cycle T: cfg_cc_rst[i] is high from T+1 for exactly RST_HOLD_CYCLES cycles (if RST bit0=0). STATUS.busy tracks the same window.
- PRDATA and PSLVERR are combinational during the access phase. Outside it, both are 0.
- Simultaneous events:
  - RST level=1 during a pulse keeps the output high past pulse end.
  - Clearing RST mid-pulse does not shorten the pulse.
- Sequencers in different complexes run independently and may overlap.
- PRESETn assertion mid-pulse immediately forces IDLE and cfg_cc_rst=0 (asynchronous).

## Structure
- Package syscfg_pkg holds:
  - offset constants (BOOT, RST, PULSE, STATUS, INFO, LOCK);
  - version constant;
  - seq_state_e enum {IDLE, ASSERT}.
- Sub-module syscfg_rst_seq: one per complex via generate.
  - Inputs: start, clk/reset.
  - Outputs: busy.
  - Parameter: HOLD.
  - Contains a 16-bit down-counter.
- Top level holds decode, register arrays, lock, and read mux.

## Test plan
- Reset, then read BOOT of complex 0 and complex NUM_CC-1 → 32'h0001_0000. INFO → {16'h0002, 8'h00, NUM_CC}. cfg_cc_rst all 0.
- Write 0x8000_0000 to 0x010, read back → 0x8000_0000 and cfg_cc_boot[1] updates the next cycle. Write LOCK=1, then write 0x010 again → PSLVERR=1 and value unchanged.
- Write 1 to 0x008 with RST_HOLD_CYCLES=16 → cfg_cc_rst[0] high for exactly 16 cycles. STATUS reads 0x3 during the pulse and 0x0 after. A second PULSE write during the pulse → PSLVERR=1 and the length is unchanged.
- Write RST=1 at 0x004 mid-pulse, then wait for the pulse to end → cfg_cc_rst[0] stays 1. Write RST=0 → it drops the next cycle.
- Access 0x0E0 with NUM_CC=2, write to 0x00C, and access 0x001 → PSLVERR=1, PRDATA=0, and no register changes.
- Start a pulse, then assert PRESETn mid-pulse → cfg_cc_rst drops immediately, busy=0, and BOOT returns to its reset value.
